// File: rtl/nmr_param_regbank.sv
// Double-buffered Avalon-MM parameter bank: shadow registers are copied to the active outputs on a sync boundary once a commit is armed.
// Optional byte enables: define NMR_PARAM_BYTEEN_EN to add the byteenable[3:0] port.
module nmr_param_regbank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 3,
    parameter logic [31:0] RESET_VAL = 32'd16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic                     read_n,
    input  logic [31:0]              writedata,
`ifdef NMR_PARAM_BYTEEN_EN
    input  logic [3:0]               byteenable,
`endif
    output logic [31:0]              readdata,
    input  logic                     sync_in,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     commit_done
);

    localparam logic [DATA_W-1:0] RST_V     = RESET_VAL[DATA_W-1:0];
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);

    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [DATA_W-1:0] active_d [NUM_CH];
    logic              pending_q, pending_d;
    logic [7:0]        commit_cnt_q, commit_cnt_d;
    logic              commit_done_q, commit_done_d;
    logic [31:0]       readdata_q, readdata_d;

    logic        wr_c;
    logic        rd_c;
    logic        commit_c;
    logic        ctrl_en_c;
    logic [31:0] wmask_c;

    // Byte mask for shadow writes and CTRL write qualification.
    always_comb begin
        wmask_c   = '1;
        ctrl_en_c = 1'b1;
`ifdef NMR_PARAM_BYTEEN_EN
        for (int b = 0; b < 4; b++) begin
            wmask_c[8*b +: 8] = {8{byteenable[b]}};
        end
        ctrl_en_c = byteenable[0];
`endif
    end

    // Next-state: commit copies the pre-edge shadow, host writes then update shadow/pending.
    always_comb begin
        wr_c          = chipselect && !write_n;
        rd_c          = chipselect && !read_n;
        commit_c      = pending_q && sync_in;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        commit_cnt_d  = commit_cnt_q;
        commit_done_d = commit_c;
        readdata_d    = readdata_q;

        if (commit_c) begin
            active_d     = shadow_q;
            pending_d    = 1'b0;
            commit_cnt_d = commit_cnt_q + 8'd1;
        end

        if (wr_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == ADDR_W'(i)) begin
                    shadow_d[i] = (shadow_q[i] & ~wmask_c[DATA_W-1:0])
                                | (writedata[DATA_W-1:0] & wmask_c[DATA_W-1:0]);
                end
            end
            // Cancel beats arm when both bits are set.
            if (address == CTRL_ADDR && ctrl_en_c) begin
                if (writedata[1]) begin
                    pending_d = 1'b0;
                end else if (writedata[0]) begin
                    pending_d = 1'b1;
                end
            end
        end

        if (rd_c) begin
            readdata_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == ADDR_W'(i)) begin
                    readdata_d = 32'(shadow_q[i]);
                end
            end
            if (address == CTRL_ADDR) begin
                readdata_d = {16'h0000, commit_cnt_q, 7'h00, pending_q};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RST_V;
                active_q[i] <= RST_V;
            end
            pending_q     <= 1'b0;
            commit_cnt_q  <= 8'd0;
            commit_done_q <= 1'b0;
            readdata_q    <= 32'd0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            commit_cnt_q  <= commit_cnt_d;
            commit_done_q <= commit_done_d;
            readdata_q    <= readdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            out_port[i*DATA_W +: DATA_W] = active_q[i];
        end
    end

    assign readdata    = readdata_q;
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_nmr_param_regbank.sv
// Bench for nmr_param_regbank: directed vector table, corner sequences, and random traffic against a behavioural model.
module tb_nmr_param_regbank;

`ifdef NMR_PARAM_BYTEEN_EN
    localparam bit BE_ON = 1'b1;
`else
    localparam bit BE_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic         read_n;
    logic [31:0]  writedata;
    logic [3:0]   byteenable;
    logic [31:0]  readdata;
    logic         sync_in;
    logic [127:0] out_port;
    logic         commit_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Behavioural model state.
    logic [31:0] m_sh  [4];
    logic [31:0] m_act [4];
    logic        m_pend;
    logic [7:0]  m_cnt;
    logic [31:0] m_rd;
    logic        m_done;

    nmr_param_regbank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
`ifdef NMR_PARAM_BYTEEN_EN
        .byteenable (byteenable),
`endif
        .readdata   (readdata),
        .sync_in    (sync_in),
        .out_port   (out_port),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic        rd;
        logic [31:0] wd;
        logic        sync;
        logic [31:0] e_rd;
        logic        e_done;
        logic [31:0] e_ch0;
        logic [31:0] e_ch1;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] m_out();
        return {m_act[3], m_act[2], m_act[1], m_act[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 32'd16;
            m_act[i] = 32'd16;
        end
        m_pend = 1'b0;
        m_cnt  = 8'd0;
        m_rd   = 32'd0;
        m_done = 1'b0;
    endtask

    // One bus cycle: drive, advance the model, clock, compare all outputs.
    task automatic step(input logic [2:0] a, input logic c, input logic wn, input logic rn,
                        input logic [31:0] d, input logic s, input logic [3:0] b);
        logic        fire;
        logic        npend;
        logic [31:0] old_sh [4];
        address    = a;
        chipselect = c;
        write_n    = wn;
        read_n     = rn;
        writedata  = d;
        sync_in    = s;
        byteenable = b;

        fire   = m_pend && s;
        old_sh = m_sh;
        if (c && !rn) begin
            if (a < 3'd4)       m_rd = m_sh[a[1:0]];
            else if (a == 3'd4) m_rd = {16'h0, m_cnt, 7'h0, m_pend};
            else                m_rd = 32'd0;
        end
        npend  = m_pend;
        m_done = fire;
        if (fire) begin
            m_act = old_sh;
            npend = 1'b0;
            m_cnt = m_cnt + 8'd1;
        end
        if (c && !wn) begin
            if (a < 3'd4) begin
                for (int bb = 0; bb < 4; bb++) begin
                    if (!BE_ON || b[bb]) m_sh[a[1:0]][8*bb +: 8] = d[8*bb +: 8];
                end
            end else if (a == 3'd4 && (!BE_ON || b[0])) begin
                if (d[1])      npend = 1'b0;
                else if (d[0]) npend = 1'b1;
            end
        end
        m_pend = npend;

        @(posedge clk);
        #1;
        chk("out_port", out_port, m_out());
        chk("commit_done", 128'(commit_done), 128'(m_done));
        chk("readdata", 128'(readdata), 128'(m_rd));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, 1'b1, d, 1'b0, 4'hF);
    endtask

    task automatic rd(input logic [2:0] a);
        step(a, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'hF);
    endtask

    task automatic sy();
        step(3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1, 4'hF);
    endtask

    task automatic arm();
        wr(3'd4, 32'd1);
    endtask

    initial begin
        int pulses;
        tbl[0] = '{3'd4, 1'b0, 1'b1, 32'd0,   1'b0, 32'h0,   1'b0, 32'd16,  32'd16};
        tbl[1] = '{3'd0, 1'b0, 1'b1, 32'd0,   1'b0, 32'd16,  1'b0, 32'd16,  32'd16};
        tbl[2] = '{3'd0, 1'b1, 1'b0, 32'd100, 1'b0, 32'd16,  1'b0, 32'd16,  32'd16};
        tbl[3] = '{3'd1, 1'b1, 1'b0, 32'd200, 1'b0, 32'd16,  1'b0, 32'd16,  32'd16};
        tbl[4] = '{3'd0, 1'b0, 1'b0, 32'd0,   1'b1, 32'd16,  1'b0, 32'd16,  32'd16};
        tbl[5] = '{3'd4, 1'b1, 1'b0, 32'd1,   1'b0, 32'd16,  1'b0, 32'd16,  32'd16};
        tbl[6] = '{3'd0, 1'b0, 1'b0, 32'd0,   1'b1, 32'd16,  1'b1, 32'd100, 32'd200};
        tbl[7] = '{3'd4, 1'b0, 1'b1, 32'd0,   1'b0, 32'h100, 1'b0, 32'd100, 32'd200};
        tbl[8] = '{3'd0, 1'b0, 1'b1, 32'd0,   1'b0, 32'd100, 1'b0, 32'd100, 32'd200};

        reset_n    = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        writedata  = '0;
        byteenable = 4'hF;
        sync_in    = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("reset_out_port", out_port, {4{32'd16}});
        chk("reset_readdata", 128'(readdata), 128'd0);
        chk("reset_commit_done", 128'(commit_done), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed table: reset reads, writes without arm, then arm + commit.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].addr, tbl[i].wr | tbl[i].rd, !tbl[i].wr, !tbl[i].rd,
                 tbl[i].wd, tbl[i].sync, 4'hF);
            chk("tbl_readdata", 128'(readdata), 128'(tbl[i].e_rd));
            chk("tbl_commit_done", 128'(commit_done), 128'(tbl[i].e_done));
            chk("tbl_ch0", 128'(out_port[31:0]), 128'(tbl[i].e_ch0));
            chk("tbl_ch1", 128'(out_port[63:32]), 128'(tbl[i].e_ch1));
        end

        // Held sync gives a single commit.
        wr(3'd2, 32'd33);
        arm();
        pulses = 0;
        repeat (5) begin
            sy();
            if (commit_done === 1'b1) pulses++;
        end
        chk("hold_sync_single_commit", 128'(pulses), 128'd1);
        rd(3'd4);
        chk("status_after_hold", 128'(readdata), 128'h200);

        // Arm while sync is high: commit waits for a later sync cycle.
        step(3'd4, 1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 4'hF);
        chk("arm_in_sync_no_commit", 128'(commit_done), 128'd0);
        sy();
        chk("later_sync_commit", 128'(commit_done), 128'd1);

        // Shadow write colliding with the commit: active takes the old shadow.
        wr(3'd2, 32'd5);
        arm();
        step(3'd2, 1'b1, 1'b0, 1'b1, 32'd7, 1'b1, 4'hF);
        chk("collide_ch2_old", 128'(out_port[95:64]), 128'd5);
        arm();
        sy();
        chk("collide_ch2_new", 128'(out_port[95:64]), 128'd7);

        // Arm then cancel: no commit.
        arm();
        wr(3'd4, 32'd2);
        sy();
        chk("cancel_no_commit", 128'(commit_done), 128'd0);
        rd(3'd4);
        chk("status_after_cancel", 128'(readdata), 128'h500);

        // Cancel in the commit cycle: commit applies, pending ends clear.
        arm();
        step(3'd4, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 4'hF);
        chk("cancel_in_commit_cycle", 128'(commit_done), 128'd1);
        rd(3'd4);
        chk("status_after_cancel_commit", 128'(readdata), 128'h600);

        // 250 more commits bring the total to 256: counter wraps to 0.
        repeat (250) begin
            arm();
            sy();
        end
        rd(3'd4);
        chk("commit_cnt_wrap", 128'(readdata), 128'h0);

        // Unmapped address.
        rd(3'd7);
        chk("unmapped_read", 128'(readdata), 128'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        arm();
        sy();
        rd(3'd4);

`ifdef NMR_PARAM_BYTEEN_EN
        wr(3'd0, 32'h1122_3344);
        step(3'd0, 1'b1, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b0, 4'b0101);
        arm();
        sy();
        chk("byteen_ch0", 128'(out_port[31:0]), 128'h11BB_33DD);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 2) == 0), 4'($urandom));
        end

        // Async reset mid-cycle with edits and an armed commit.
        wr(3'd1, 32'h55);
        rd(3'd1);
        arm();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_out_port", out_port, {4{32'd16}});
        chk("async_reset_readdata", 128'(readdata), 128'd0);
        chk("async_reset_commit_done", 128'(commit_done), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sy();
        chk("no_commit_after_reset", 128'(commit_done), 128'd0);
        rd(3'd1);
        chk("shadow_discarded", 128'(readdata), 128'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nmr_param_regbank.md
Name: nmr_param_regbank

Overview:
- Parametrised, double-buffered Avalon-MM parameter register bank driving NMR sequencer timing and parameter inputs (delays, pulse lengths, counts).
- Host writes shadow registers at any time; they are copied to the active outputs together, only on a sequencer sync boundary, after the host arms a commit.
- Prevents torn multi-register updates mid-sequence.
- Single instance replaces several single-word PIO parameter ports.

Parameters:
- NUM_CH, 4, number of parameter channels (1..15).
- DATA_W, 32, width of each channel (1..32).
- ADDR_W, 3, Avalon word-address width; 2^ADDR_W >= NUM_CH+1 is required.
- RESET_VAL, 16, reset value of every shadow and active channel, truncated to DATA_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- sync_in  in  1  sequencer boundary strobe, high for 1+ cycles when safe to update.
- out_port  out  NUM_CH*DATA_W  active channels, ch0 in LSBs.
- commit_done  out  1  one-cycle pulse when a commit is applied.

Behaviour:
Address map
- Addresses 0..NUM_CH-1: shadow channel n. Read/write; writedata[DATA_W-1:0] is used.
- Address NUM_CH: CTRL/STATUS.
  - Write bit0=1 arms a commit (pending<=1).
  - Write bit1=1 cancels (pending<=0); cancel wins if both bits are 1.
  - Read: bit0=pending, bits[15:8]=commit_cnt, all other bits 0.
- Other addresses: reads return 0; writes are ignored.

Write and read
- Write occurs when chipselect && !write_n.
- Read latency is 1: readdata is valid the cycle after chipselect && !read_n.
- readdata holds its value when no read is issued.

Commit
- Commit fires in a cycle where pending && sync_in, evaluated on pending as registered at that cycle's start.
- Next edge: every active<=shadow, pending<=0, commit_cnt<=commit_cnt+1 (8-bit, wraps 255->0), commit_done=1 for exactly one cycle.
- sync_in held high does not cause repeated commits; re-arming is required.

Simultaneous events
- Shadow write in the commit cycle: active takes the OLD shadow value; the new value stays in shadow for the next commit.
- Arm write in a cycle with sync_in high: pending becomes 1 and the commit waits for a later sync_in cycle.
- Cancel write in a cycle where commit fires: the commit still applies and pending ends 0.

Reset
- Async assert clears regardless of clock: shadow=active=RESET_VAL, pending=0, commit_cnt=0, commit_done=0, readdata=0.
- Reset mid-sequence discards shadow edits and any armed commit.
- out_port = concatenated active registers, driven directly from flops.

Optional Feature:
- Macro: NMR_PARAM_BYTEEN_EN.
- Defined: adds input port byteenable [3:0]. Shadow writes update only enabled bytes; bytes beyond DATA_W are ignored. CTRL writes act only if byteenable[0]=1.
- Undefined: no byteenable port; every write is a full-word write.

Test Plan:
- Reset release, NUM_CH=4 -> out_port each field 16; read addr 4 -> 0x00000000; read addr 0 -> 16 one cycle after request.
- Write ch0=100, ch1=200, no arm, pulse sync_in -> out_port unchanged (16s); arm (addr 4 <= 1), pulse sync_in -> ch0=100, ch1=200, commit_done one cycle, status 0x00000100.
- Arm, hold sync_in high 5 cycles -> exactly one commit, commit_cnt+1; arm in a sync_in-high cycle -> no commit until the next sync_in cycle.
- Shadow ch2<=7 in the same cycle as commit (old shadow 5) -> active ch2=5; next arm+sync -> 7. Arm then cancel (addr 4 <= 2) then sync -> no change, pending=0.
- 256 commits -> commit_cnt wraps to 0; read addr 7 -> 0; write addr 7 -> no state change. Assert reset_n mid-cycle with pending=1 -> immediate RESET_VAL outputs, pending 0.
- With NMR_PARAM_BYTEEN_EN: ch0=0x11223344, write 0xAABBCCDD with byteenable=0b0101, commit -> ch0=0x11BB33DD.
